exp1_sweeper: RTL and testbench
===============================

EXP1_SWEEPER -- requirements
Module: exp1_sweeper

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 100: clock cycles each input vector is held before its result is sampled; legal range 1..65535.
REQ-002 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port resetN  input  1  reset, asynchronous, active-low.
REQ-004 Port start  input  1  begin a sweep; level sampled each cycle.
REQ-005 Port stepMode  input  1  0 = auto advance, 1 = manual advance via stepReq.
REQ-006 Port stepReq  input  1  manual advance request, one-cycle pulse expected.
REQ-007 Ports l1, l2, x, y, z  input  1 each  results returned by the logic block under test.
REQ-008 Ports a, b, c  output  1 each  stimulus to the block under test; {a,b,c} = vecIdx.
REQ-009 Port vecIdx  output  3  index of the vector currently applied.
REQ-010 Port busy  output  1  high while a sweep is in progress.
REQ-011 Port done  output  1  one-cycle pulse at sweep completion.
REQ-012 Port truthTable  output  40  captured results; entry i at bits [5i+4:5i] = {l1,l2,x,y,z}.

Function
REQ-013 The FSM SHALL have states IDLE, HOLD, SAMPLE and FIN.
REQ-014 IDLE: start=1 SHALL clear truthTable to 0, set vecIdx=0, load holdCnt=HOLD_CYCLES-1, and enter HOLD.
REQ-015 HOLD: holdCnt SHALL decrement by 1 per cycle and saturate at 0.
REQ-016 HOLD with stepMode=0: holdCnt==0 SHALL move to SAMPLE on the next edge.
REQ-017 HOLD with stepMode=1: the block SHALL move to SAMPLE only on a cycle where holdCnt==0 and stepReq=1; stepReq while holdCnt>0 SHALL be discarded, not queued.
REQ-018 SAMPLE (one cycle): the block SHALL write {l1,l2,x,y,z} into entry vecIdx.
REQ-019 SAMPLE with vecIdx<7: the block SHALL increment vecIdx, reload holdCnt=HOLD_CYCLES-1, and return to HOLD.
REQ-020 SAMPLE with vecIdx==7: the block SHALL go to FIN with vecIdx wrapped to 0.
REQ-021 FIN (one cycle): done SHALL be 1, then the block SHALL enter IDLE; done SHALL be 0 in all other states.
REQ-022 busy SHALL be 1 in HOLD and SAMPLE and 0 in IDLE and FIN.
REQ-023 start SHALL be ignored outside IDLE; start held high through FIN SHALL begin a new sweep from the IDLE cycle after FIN.
REQ-024 Auto-mode timing: each vector SHALL be applied for HOLD_CYCLES+1 cycles; start-sampled edge to done high SHALL be 8*(HOLD_CYCLES+1)+1 cycles.
REQ-025 truthTable SHALL hold its value in IDLE until the next start; entries not yet sampled SHALL read 0 during a sweep.
REQ-026 a, b, c, vecIdx, busy, done SHALL be driven directly from registers, with no combinational path from any input.
REQ-027 Changing stepMode mid-sweep SHALL take effect on the next HOLD-state evaluation.

Reset
REQ-028 resetN=0 SHALL immediately force state IDLE, vecIdx=0, a=b=c=0, holdCnt=0, busy=0, done=0, truthTable=0, regardless of clk.
REQ-029 Reset asserted mid-sweep SHALL abort it without a done pulse; after release the block SHALL wait for start.

Verification
REQ-030 HOLD_CYCLES=4, stepMode=0, DUT model z=a^b^c, other inputs 0, start pulse -> abc steps 000..111, 5 cycles each; done 41 cycles after the start edge; truthTable bits z at entries 1,2,4,7 set, all others 0.
REQ-031 HOLD_CYCLES=4, stepMode=1, stepReq pulses at holdCnt==2 and then at holdCnt==0 -> first pulse ignored, advance only on second; vecIdx 0->1.
REQ-032 HOLD_CYCLES=1, all results 1, start held high continuously -> back-to-back sweeps, done every 18 cycles, truthTable = 40'hFF_FFFF_FFFF after each sweep.
REQ-033 resetN pulsed low asynchronously (mid-cycle) during vector 5 -> a,b,c,busy,truthTable go 0 before the next edge; no done; idle until start.
REQ-034 start pulsed during HOLD of vector 3 -> no restart; vecIdx continues 3->4; truthTable entries 0..2 unchanged.

Source files
------------

// File: rtl/exp1_sweeper.sv
// Truth-table sweeper: drives the 3-bit stimulus {a,b,c} through 000..111 and
// captures the five result bits returned for each vector into a 40-bit table.
module exp1_sweeper #(
   parameter int unsigned HOLD_CYCLES = 100
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        start,
   input  logic        stepMode,
   input  logic        stepReq,
   input  logic        l1,
   input  logic        l2,
   input  logic        x,
   input  logic        y,
   input  logic        z,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic [2:0]  vecIdx,
   output logic        busy,
   output logic        done,
   output logic [39:0] truthTable
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_SAMPLE = 2'd2,
      S_FIN    = 2'd3
   } state_t;

   localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

   state_t      r_state;
   logic [15:0] r_hold_cnt;
   logic [2:0]  r_vec_idx;
   logic        r_busy;
   logic        r_done;
   logic [39:0] r_tt;

   state_t      w_state_nxt;
   logic [15:0] w_hold_nxt;
   logic [2:0]  w_vec_nxt;
   logic [39:0] w_tt_nxt;
   logic [5:0]  w_slot;

   // Bit offset of the current entry: 5 * vecIdx.
   assign w_slot = {1'b0, r_vec_idx, 2'b00} + {3'b000, r_vec_idx};

   always_comb begin
      // NOTE: every signal gets its hold value first so no path can infer a latch.
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_cnt;
      w_vec_nxt   = r_vec_idx;
      w_tt_nxt    = r_tt;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_tt_nxt    = '0;
               w_vec_nxt   = '0;
               w_hold_nxt  = HOLD_LOAD;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            // A manual step request only counts once the hold time has elapsed.
            if (r_hold_cnt != 16'd0) begin
               w_hold_nxt = r_hold_cnt - 16'd1;
            end else if (!stepMode || stepReq) begin
               w_state_nxt = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            w_tt_nxt[w_slot +: 5] = {l1, l2, x, y, z};
            w_vec_nxt             = r_vec_idx + 3'd1;
            if (r_vec_idx == 3'd7) begin
               w_state_nxt = S_FIN;
            end else begin
               w_hold_nxt  = HOLD_LOAD;
               w_state_nxt = S_HOLD;
            end
         end
         S_FIN: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // NOTE: busy/done are registered from the next state so they change with
   // the state itself and no input reaches them combinationally.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state    <= S_IDLE;
         r_hold_cnt <= '0;
         r_vec_idx  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_tt       <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_vec_idx  <= w_vec_nxt;
         r_busy     <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_SAMPLE);
         r_done     <= (w_state_nxt == S_FIN);
         r_tt       <= w_tt_nxt;
      end
   end

   assign {a, b, c}  = r_vec_idx;
   assign vecIdx     = r_vec_idx;
   assign busy       = r_busy;
   assign done       = r_done;
   assign truthTable = r_tt;

endmodule

// File: tb/tb_exp1_sweeper.sv
// Directed bench for exp1_sweeper: auto and manual sweeps, mid-sweep start and
// reset, and back-to-back sweeps with start held high.
module tb_exp1_sweeper;

   logic clk;
   logic resetN;

   // Instance with HOLD_CYCLES = 4; its block under test computes z = a^b^c.
   logic        start4, mode4, req4;
   logic        a4, b4, c4, busy4, done4;
   logic [2:0]  vec4;
   logic [39:0] tt4;
   logic        zero;

   // Instance with HOLD_CYCLES = 1; every result bit returns 1.
   logic        start1, mode1, req1, one;
   logic        a1, b1, c1, busy1, done1;
   logic [2:0]  vec1;
   logic [39:0] tt1;

   int n_cmp;
   int n_err;
   int k;

   assign zero = 1'b0;
   assign one  = 1'b1;

   exp1_sweeper #(.HOLD_CYCLES(4)) u_dut4 (
      .clk(clk), .resetN(resetN), .start(start4), .stepMode(mode4), .stepReq(req4),
      .l1(zero), .l2(zero), .x(zero), .y(zero), .z(a4 ^ b4 ^ c4),
      .a(a4), .b(b4), .c(c4), .vecIdx(vec4), .busy(busy4), .done(done4),
      .truthTable(tt4)
   );

   exp1_sweeper #(.HOLD_CYCLES(1)) u_dut1 (
      .clk(clk), .resetN(resetN), .start(start1), .stepMode(mode1), .stepReq(req1),
      .l1(one), .l2(one), .x(one), .y(one), .z(one),
      .a(a1), .b(b1), .c(c1), .vecIdx(vec1), .busy(busy1), .done(done1),
      .truthTable(tt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d, t=%0t)", tag, got, exp, k, $time);
      end
   endtask

   // One rising edge, then settle on the falling edge where outputs are sampled.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         k++;
      end
   endtask

   // Raise start for exactly one sampling edge; k=0 right after that edge.
   task automatic pulse_start4();
      start4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start4 = 1'b0;
      k = 0;
   endtask

   initial begin
      int exp_vec;
      int done_hits;
      int busy_hits;
      int done_edges[$];

      n_cmp  = 0;
      n_err  = 0;
      k      = 0;
      resetN = 1'b0;
      start4 = 1'b0; mode4 = 1'b0; req4 = 1'b0;
      start1 = 1'b0; mode1 = 1'b0; req1 = 1'b0;

      // Reset state.
      #3;
      check("rst_abc",  {a4, b4, c4}, 3'b000);
      check("rst_vec",  vec4, 3'd0);
      check("rst_busy", busy4, 1'b0);
      check("rst_done", done4, 1'b0);
      check("rst_tt",   tt4, 40'h0);
      @(negedge clk);
      @(negedge clk);
      resetN = 1'b1;
      step(2);
      check("idle_busy", busy4, 1'b0);

      // Auto sweep, 5 cycles per vector; done 8*(4+1)+1 edges counting the start edge.
      pulse_start4();
      check("auto_busy0", busy4, 1'b1);
      check("auto_vec0",  vec4, 3'd0);
      for (int i = 1; i <= 45; i++) begin
         step(1);
         exp_vec = (k < 40) ? k / 5 : 0;
         check("auto_vec",  vec4, exp_vec[2:0]);
         check("auto_abc",  {a4, b4, c4}, exp_vec[2:0]);
         check("auto_done", done4, (k + 1) == 41);
         check("auto_busy", busy4, k < 40);
         if (k == 22) check("auto_tt_partial", tt4, 40'h00_0000_0420);
         if (k == 40) check("auto_tt_final",   tt4, 40'h08_0010_0420);
      end
      check("auto_tt_hold", tt4, 40'h08_0010_0420);

      // Manual mode: request at holdCnt==2 is dropped, request at holdCnt==0 advances.
      mode4 = 1'b1;
      pulse_start4();
      check("man_tt_clear", tt4, 40'h0);
      step(1);
      req4 = 1'b1;
      step(1);
      req4 = 1'b0;
      step(4);
      check("man_early_ignored", vec4, 3'd0);
      check("man_busy", busy4, 1'b1);
      req4 = 1'b1;
      step(1);
      req4 = 1'b0;
      check("man_sample_vec", vec4, 3'd0);
      step(1);
      check("man_advance", vec4, 3'd1);

      // Switching back to auto mid-sweep takes effect in the next HOLD.
      mode4 = 1'b0;
      step(5);
      check("mode_switch_vec", vec4, 3'd2);

      // start during HOLD of vector 3 is ignored.
      step(6);
      check("mid_start_vec3", vec4, 3'd3);
      check("mid_start_tt_before", tt4, 40'h00_0000_0420);
      start4 = 1'b1;
      step(1);
      start4 = 1'b0;
      check("mid_start_vec", vec4, 3'd3);
      check("mid_start_busy", busy4, 1'b1);
      step(3);
      check("mid_start_next", vec4, 3'd4);
      check("mid_start_tt_lo", tt4[14:0], 15'h0420);

      // Asynchronous reset mid-cycle during vector 5.
      step(6);
      check("pre_rst_vec", vec4, 3'd5);
      check("pre_rst_tt",  tt4, 40'h00_0010_0420);
      #2 resetN = 1'b0;
      #1;
      check("async_abc",  {a4, b4, c4}, 3'b000);
      check("async_busy", busy4, 1'b0);
      check("async_done", done4, 1'b0);
      check("async_tt",   tt4, 40'h0);
      #1 resetN = 1'b1;
      done_hits = 0;
      busy_hits = 0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (done4) done_hits++;
         if (busy4) busy_hits++;
      end
      check("post_rst_no_done", done_hits, 0);
      check("post_rst_idle",    busy_hits, 0);
      check("post_rst_vec",     vec4, 3'd0);

      // Back-to-back sweeps with HOLD_CYCLES=1 and start held high.
      start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      k = 0;
      for (int i = 1; i <= 60; i++) begin
         step(1);
         if (done1) begin
            done_edges.push_back(k);
            check("b2b_tt", tt1, 40'hFF_FFFF_FFFF);
            check("b2b_busy_fin", busy1, 1'b0);
         end
         if (k == 17) check("b2b_idle_busy", busy1, 1'b0);
         if (k == 18) check("b2b_tt_cleared", tt1, 40'h0);
         if (k == 19) check("b2b_restart_busy", busy1, 1'b1);
      end
      start1 = 1'b0;
      check("b2b_done_count", done_edges.size(), 3);
      if (done_edges.size() == 3) begin
         check("b2b_first_done", done_edges[0], 16);
         check("b2b_period1", done_edges[1] - done_edges[0], 18);
         check("b2b_period2", done_edges[2] - done_edges[1], 18);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
